// File: rtl/elevator_door_ctrl.sv
// Car-door controller: times door travel and dwell, reverses on obstruction or
// buttons, and raises a hold interlock toward the car controller while the door is not shut.
module elevator_door_ctrl #(
  parameter int MOVE_CYCLES  = 50,
  parameter int DWELL_CYCLES = 200,
  parameter int MAX_REOPEN   = 3,
  parameter int CW           = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       complete,
  input  logic [1:0] direction,
  input  logic       over_weight,
  input  logic [2:0] out_floor,
  input  logic       obstruct,
  input  logic       open_btn,
  input  logic       close_btn,
  output logic [1:0] door_motor,
  output logic       door_open,
  output logic       door_closed,
  output logic       hold,
  output logic [2:0] arrived_floor,
  output logic       fault
);

  localparam int RW = $clog2(MAX_REOPEN + 1);
  localparam logic [CW-1:0] MOVE_C  = CW'(MOVE_CYCLES);
  localparam logic [CW-1:0] DWELL_C = CW'(DWELL_CYCLES);
  localparam logic [RW-1:0] MAX_C   = RW'(MAX_REOPEN);

  localparam logic [1:0] MOTOR_STOP  = 2'b00;
  localparam logic [1:0] MOTOR_OPEN  = 2'b01;
  localparam logic [1:0] MOTOR_CLOSE = 2'b10;

  typedef enum logic [1:0] {S_CLOSED, S_OPENING, S_DWELL, S_CLOSING} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] reopen_q, reopen_d;
  logic          complete_q;
  logic          fault_q, fault_d;
  logic [2:0]    floor_q, floor_d;
  logic [1:0]    motor_q, motor_d;
  logic          open_q, open_d;
  logic          closed_q, closed_d;
  logic          hold_q, hold_d;

  logic arrival;
  logic reverse;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    pos_d    = pos_q;
    dwell_d  = dwell_q;
    reopen_d = reopen_q;
    fault_d  = fault_q;
    floor_d  = floor_q;
    arrival  = complete & ~complete_q;
    reverse  = obstruct | open_btn | over_weight;

    unique case (state_q)
      S_CLOSED: begin
        reopen_d = '0;
        if (arrival || (open_btn && direction == 2'd0 && complete) || (over_weight && complete)) begin
          state_d = S_OPENING;
          floor_d = out_floor;
        end
      end
      S_OPENING: begin
        // A reverse at the fully-open end still spends one cycle here.
        if (pos_q >= MOVE_C - CW'(1)) begin
          state_d = S_DWELL;
          pos_d   = MOVE_C;
          dwell_d = '0;
        end else begin
          pos_d = pos_q + CW'(1);
        end
      end
      S_DWELL: begin
        if (!fault_q) begin
          if (open_btn || obstruct || over_weight) begin
            dwell_d = '0;
          end else if (close_btn || dwell_q == DWELL_C - CW'(1)) begin
            state_d = S_CLOSING;
          end else begin
            dwell_d = dwell_q + CW'(1);
          end
        end
      end
      S_CLOSING: begin
        // Reverse keeps the current position and beats reaching fully closed.
        if (reverse) begin
          state_d = S_OPENING;
          if (obstruct) begin
            reopen_d = reopen_q + RW'(1);
            if (reopen_q + RW'(1) == MAX_C) fault_d = 1'b1;
          end
        end else if (pos_q <= CW'(1)) begin
          pos_d   = '0;
          state_d = S_CLOSED;
        end else begin
          pos_d = pos_q - CW'(1);
        end
      end
      default: state_d = S_CLOSED;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    motor_d  = (state_d == S_OPENING) ? MOTOR_OPEN :
               (state_d == S_CLOSING) ? MOTOR_CLOSE : MOTOR_STOP;
    open_d   = (state_d == S_DWELL);
    closed_d = (state_d == S_CLOSED);
    hold_d   = (state_d != S_CLOSED) | fault_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CLOSED;
      pos_q      <= '0;
      dwell_q    <= '0;
      reopen_q   <= '0;
      complete_q <= 1'b1;
      fault_q    <= 1'b0;
      floor_q    <= '0;
      motor_q    <= MOTOR_STOP;
      open_q     <= 1'b0;
      closed_q   <= 1'b1;
      hold_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pos_q      <= pos_d;
      dwell_q    <= dwell_d;
      reopen_q   <= reopen_d;
      complete_q <= complete;
      fault_q    <= fault_d;
      floor_q    <= floor_d;
      motor_q    <= motor_d;
      open_q     <= open_d;
      closed_q   <= closed_d;
      hold_q     <= hold_d;
    end
  end

  assign door_motor    = motor_q;
  assign door_open     = open_q;
  assign door_closed   = closed_q;
  assign hold          = hold_q;
  assign arrived_floor = floor_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_elevator_door_ctrl.sv
// Bench for elevator_door_ctrl: directed scenarios plus a random run, all checked
// every cycle against a position/direction model of the door.
module tb_elevator_door_ctrl;

  localparam int MOVE  = 50;
  localparam int DWELL = 200;
  localparam int MAXR  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       complete = 1'b1;
  logic [1:0] direction = 2'd0;
  logic       over_weight = 1'b0;
  logic [2:0] out_floor = 3'd0;
  logic       obstruct = 1'b0;
  logic       open_btn = 1'b0;
  logic       close_btn = 1'b0;
  logic [1:0] door_motor;
  logic       door_open, door_closed, hold, fault;
  logic [2:0] arrived_floor;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  elevator_door_ctrl dut (
    .clk(clk), .reset(reset), .complete(complete), .direction(direction),
    .over_weight(over_weight), .out_floor(out_floor), .obstruct(obstruct),
    .open_btn(open_btn), .close_btn(close_btn), .door_motor(door_motor),
    .door_open(door_open), .door_closed(door_closed), .hold(hold),
    .arrived_floor(arrived_floor), .fault(fault)
  );

  always #5 clk = ~clk;

  // Door model: travel direction (+1/-1/0) and position; stationary at MOVE is dwell, at 0 is shut.
  typedef struct {
    int         dir;
    int         pos;
    int         dwell;
    int         reopen;
    bit         cq;
    bit         flt;
    logic [2:0] floor;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.dir = 0; r.pos = 0; r.dwell = 0; r.reopen = 0; r.cq = 1'b1; r.flt = 1'b0; r.floor = 3'd0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, logic cmp, logic [1:0] dir_in, logic ow,
                                        logic [2:0] fl, logic obs, logic ob, logic cb);
    model_t n = c;
    bit arrival = cmp && !c.cq;
    n.cq = cmp;
    if (c.dir == 0 && c.pos == 0) begin
      n.reopen = 0;
      if (arrival || (ob && dir_in == 2'd0 && cmp) || (ow && cmp)) begin
        n.dir   = 1;
        n.floor = fl;
      end
    end else if (c.dir == 1) begin
      n.pos = (c.pos + 1 > MOVE) ? MOVE : c.pos + 1;
      if (n.pos == MOVE) begin
        n.dir   = 0;
        n.dwell = 0;
      end
    end else if (c.dir == 0) begin
      if (!c.flt) begin
        if (ob || obs || ow) n.dwell = 0;
        else if (cb || c.dwell == DWELL - 1) n.dir = -1;
        else n.dwell = c.dwell + 1;
      end
    end else begin
      if (obs || ob || ow) begin
        n.dir = 1;
        if (obs) begin
          n.reopen = c.reopen + 1;
          if (n.reopen == MAXR) n.flt = 1'b1;
        end
      end else begin
        n.pos = c.pos - 1;
        if (n.pos == 0) n.dir = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else m <= model_step(m, complete, direction, over_weight, out_floor, obstruct, open_btn, close_btn);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit shut, full;
      shut = (m.dir == 0 && m.pos == 0);
      full = (m.dir == 0 && m.pos == MOVE);
      check("cmp_motor", door_motor, (m.dir > 0) ? 2'b01 : (m.dir < 0) ? 2'b10 : 2'b00);
      check("cmp_open", door_open, full);
      check("cmp_closed", door_closed, shut);
      check("cmp_hold", hold, !shut || m.flt);
      check("cmp_floor", arrived_floor, m.floor);
      check("cmp_fault", fault, m.flt);
    end
  end

  task automatic wait_motor(input string name, input logic [1:0] v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (door_motor !== v && n < 2000);
    check(name, door_motor, v);
  endtask

  task automatic wait_open(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (door_open !== 1'b1 && n < 2000);
    check(name, door_open, 1'b1);
  endtask

  task automatic wait_closed(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (door_closed !== 1'b1 && n < 2000);
    check(name, door_closed, 1'b1);
  endtask

  task automatic arrive(input logic [2:0] fl);
    @(negedge clk);
    out_floor = fl;
    complete  = 1'b0;
    @(negedge clk);
    complete  = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_motor"}, door_motor, 2'b00);
    check({tag, "_open"}, door_open, 1'b0);
    check({tag, "_closed"}, door_closed, 1'b1);
    check({tag, "_hold"}, hold, 1'b0);
    check({tag, "_floor"}, arrived_floor, 3'd0);
    check({tag, "_fault"}, fault, 1'b0);
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    #19 check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    // T1: basic stop at floor 5, hold asserted for the whole 50+200+50 cycle visit.
    arrive(3'd5);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!hold) break;
      n++;
    end
    check("t1_hold_cycles", n, 300);
    check("t1_floor", arrived_floor, 3'd5);
    check("t1_closed", door_closed, 1'b1);

    // T2: obstruct 20 cycles into closing (pos 30) reopens in 20 cycles.
    arrive(3'd2);
    wait_motor("t2_closing", 2'b10, n);
    repeat (20) @(negedge clk);
    obstruct = 1'b1;
    @(negedge clk);
    obstruct = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && door_motor == 2'b01; i++) begin
      n++;
      @(negedge clk);
    end
    check("t2_reopen_cycles", n, 20);
    check("t2_dwell", door_open, 1'b1);
    wait_closed("t2_closed");

    // T3: three obstructed closings in one stop latch the fault.
    arrive(3'd3);
    for (int k = 0; k < 3; k++) begin
      wait_motor("t3_closing", 2'b10, n);
      obstruct = 1'b1;
      @(negedge clk);
      obstruct = 1'b0;
    end
    check("t3_fault", fault, 1'b1);
    repeat (600) @(negedge clk);
    check("t3_stuck_open", door_open, 1'b1);
    check("t3_stuck_hold", hold, 1'b1);
    #2 reset = 1'b0;
    #1 check("t3_reset_fault", fault, 1'b0);
    check("t3_reset_closed", door_closed, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // T4: dwell buttons.
    arrive(3'd4);
    wait_open("t4_open");
    repeat (150) @(negedge clk);
    open_btn = 1'b1;
    repeat (10) @(negedge clk);
    open_btn = 1'b0;
    wait_motor("t4_closing", 2'b10, n);
    check("t4_close_after_release", n, 200);
    open_btn = 1'b1;
    @(negedge clk);
    open_btn = 1'b0;
    check("t4_btn_reverse", door_motor, 2'b01);
    wait_open("t4_reopen");
    obstruct  = 1'b1;
    close_btn = 1'b1;
    @(negedge clk);
    check("t4_close_blocked", door_open, 1'b1);
    obstruct = 1'b0;
    @(negedge clk);
    check("t4_close_now", door_motor, 2'b10);
    close_btn = 1'b0;
    wait_closed("t4_closed");

    // T5: over_weight opens a parked car and pins the dwell timer.
    over_weight = 1'b1;
    @(negedge clk);
    check("t5_ow_open", door_motor, 2'b01);
    wait_open("t5_dwell");
    repeat (300) @(negedge clk);
    check("t5_held_open", door_open, 1'b1);
    over_weight = 1'b0;
    wait_motor("t5_closing", 2'b10, n);
    check("t5_close_after_drop", n, 200);
    wait_closed("t5_closed");

    // T6: reset mid-opening, released with complete already high.
    arrive(3'd6);
    repeat (25) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values("t6_async");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_arrival", door_closed, 1'b1);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      complete    = ($urandom_range(0, 99) < 90);
      direction   = 2'($urandom_range(0, 2));
      out_floor   = 3'($urandom_range(0, 7));
      obstruct    = ($urandom_range(0, 99) < 3);
      open_btn    = ($urandom_range(0, 99) < 2);
      close_btn   = ($urandom_range(0, 99) < 3);
      over_weight = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 2999) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
